// File: rtl/dft_pkg.sv
// dft_pkg: shared sizing defaults, FSM state type and coefficient pair type for the DFT bin accumulator
package dft_pkg;
   localparam int DFT_WIDTH = 12;
   localparam int DFT_LOG2N = 4;
   localparam int DFT_ACC_W = 2*DFT_WIDTH+DFT_LOG2N;
   typedef enum logic [2:0] {IDLE, REQ, WAIT_COEF, WAIT_X, MAC, DONE} state_t;
   typedef logic signed [1:0][DFT_WIDTH-1:0] coef_pair_t;
endpackage

// File: rtl/dft_cmac.sv
// dft_cmac: registered signed complex multiply-accumulate, re += x*c0, im -= x*c1
module dft_cmac import dft_pkg::*; #(
   parameter int WIDTH = DFT_WIDTH,
   parameter int ACC_W = DFT_ACC_W
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] c0,
   input  logic signed [WIDTH-1:0] c1,
   output logic signed [ACC_W-1:0] re,
   output logic signed [ACC_W-1:0] im
);
   logic signed [2*WIDTH-1:0] p_re, p_im;
   assign p_re = x * c0;
   assign p_im = x * c1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re <= '0;
         im <= '0;
      end else if (clr) begin
         re <= '0;
         im <= '0;
      end else if (en) begin
         re <= re + ACC_W'(p_re);
         im <= im - ACC_W'(p_im);
      end
   end
endmodule

// File: rtl/dft_bin_acc.sv
// dft_bin_acc: single-bin DFT, steps n over N samples, fetches twiddles from the coefficient table and accumulates X[k]
module dft_bin_acc import dft_pkg::*; #(
   parameter int WIDTH = DFT_WIDTH,
   parameter int LOG2N = DFT_LOG2N,
   parameter int ACC_W = 2*WIDTH+LOG2N
)(
   input  logic                    i_sys_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [LOG2N-1:0]        i_k,
   input  logic signed [WIDTH-1:0] i_x,
   input  logic                    i_x_valid,
   output logic                    o_x_ready,
   output logic [WIDTH-1:0]        o_coef_index,
   output logic                    o_coef_req,
   input  logic                    i_coef_done,
   input  logic [1:0][WIDTH-1:0]   i_c,
   output logic signed [ACC_W-1:0] o_re,
   output logic signed [ACC_W-1:0] o_im,
   output logic                    o_valid,
   output logic                    o_busy
);
   state_t state, nxt;
   logic [LOG2N-1:0] k, n, phase;
   logic signed [WIDTH-1:0] x, c0, c1;
   logic signed [ACC_W-1:0] acc_re, acc_im, res_re, res_im;
   logic start_ok;
   assign start_ok = (state == IDLE) && i_start;
   always_ff @(posedge i_sys_clk or negedge i_reset) begin
      if (!i_reset) state <= IDLE;
      else          state <= nxt;
   end
   always_comb begin
      nxt          = state;
      o_coef_req   = state == REQ;
      o_x_ready    = state == WAIT_X;
      o_valid      = state == DONE;
      o_busy       = state != IDLE;
      o_coef_index = WIDTH'(phase) << (WIDTH-LOG2N);
      // the fresh sum is shown during the valid pulse, the held copy afterwards
      o_re         = (state == DONE) ? acc_re : res_re;
      o_im         = (state == DONE) ? acc_im : res_im;
      case (state)
         IDLE:      if (i_start) nxt = REQ;
         REQ:       nxt = WAIT_COEF;
         WAIT_COEF: if (i_coef_done) nxt = WAIT_X;
         WAIT_X:    if (i_x_valid) nxt = MAC;
         MAC:       nxt = (&n) ? DONE : REQ;
         default:   nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_sys_clk or negedge i_reset) begin
      if (!i_reset) begin
         k      <= '0;
         n      <= '0;
         phase  <= '0;
         x      <= '0;
         c0     <= '0;
         c1     <= '0;
         res_re <= '0;
         res_im <= '0;
      end else begin
         if (start_ok) begin
            k     <= i_k;
            n     <= '0;
            phase <= '0;
         end
         if (state == WAIT_COEF && i_coef_done) begin
            c0 <= i_c[0];
            c1 <= i_c[1];
         end
         if (state == WAIT_X && i_x_valid) x <= i_x;
         // phase wraps naturally at N, giving k*n mod N without a multiplier
         if (state == MAC && !(&n)) begin
            n     <= n + 1'b1;
            phase <= phase + k;
         end
         if (state == DONE) begin
            res_re <= acc_re;
            res_im <= acc_im;
         end
      end
   end
   dft_cmac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_cmac (
      .clk   (i_sys_clk),
      .rst_n (i_reset),
      .clr   (start_ok),
      .en    (state == MAC),
      .x     (x),
      .c0    (c0),
      .c1    (c1),
      .re    (acc_re),
      .im    (acc_im)
   );
endmodule

// File: tb/tb_dft_bin_acc.sv
// tb_dft_bin_acc: randomized bench for dft_bin_acc with a latency-3 twiddle table model and a sum-of-products reference
module tb_dft_bin_acc;
   import dft_pkg::*;
   logic clk = 0, rst_n = 0, i_start = 0, i_x_valid = 0, i_coef_done = 0;
   logic [3:0] i_k = '0;
   logic signed [11:0] i_x = '0;
   coef_pair_t i_c = '0;
   logic o_x_ready, o_coef_req, o_valid, o_busy;
   logic [11:0] o_coef_index;
   logic signed [27:0] o_re, o_im;
   int cos_tab[4096], sin_tab[4096];
   int xs[16];
   longint exp_re, exp_im, hold_re, hold_im;
   int n_chk = 0, n_pass = 0;
   int mdl_k = 0, req_cnt = 0, xcnt = 0, vcnt = 0, tcnt = 0, tidx = 0;
   int obs_idx[16];
   bit gaps = 0, glitch = 0, prev_busy = 0;
   always #5 clk = ~clk;
   dft_bin_acc dut (
      .i_sys_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_k(i_k), .i_x(i_x),
      .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .o_coef_index(o_coef_index),
      .o_coef_req(o_coef_req), .i_coef_done(i_coef_done), .i_c(i_c), .o_re(o_re),
      .o_im(o_im), .o_valid(o_valid), .o_busy(o_busy)
   );
   task automatic chk(string nm, longint act, longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, req);
   endtask
   function automatic void model(int k);
      exp_re = 0;
      exp_im = 0;
      for (int n = 0; n < 16; n++) begin
         exp_re += longint'(xs[n]) * cos_tab[((k*n) % 16) * 256];
         exp_im -= longint'(xs[n]) * sin_tab[((k*n) % 16) * 256];
      end
   endfunction
   // table answers 3 cycles after a request; optional junk done during the request cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         tcnt = 0;
         i_coef_done = 0;
      end else if (o_coef_req) begin
         tcnt = 3;
         tidx = int'(o_coef_index);
         i_coef_done = glitch;
         i_c = glitch ? {12'h7FF, 12'h801} : '0;
      end else if (tcnt > 0) begin
         tcnt--;
         i_coef_done = (tcnt == 0);
         i_c[0] = 12'(cos_tab[tidx]);
         i_c[1] = 12'(sin_tab[tidx]);
      end else i_coef_done = 0;
   end
   always @(posedge clk) begin
      #2;
      i_x = 12'(xs[xcnt < 16 ? xcnt : 15]);
      i_x_valid = gaps ? ($urandom_range(0, 2) == 0) : 1'b1;
   end
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_re = 0;
         hold_im = 0;
         prev_busy = 0;
         chk("reset_re", o_re, 0);
         chk("reset_valid", o_valid, 0);
      end else begin
         if (o_busy && !prev_busy) begin
            req_cnt = 0;
            xcnt = 0;
            vcnt = 0;
         end
         prev_busy = o_busy;
         if (o_coef_req) begin
            chk("coef_index", o_coef_index, ((mdl_k * req_cnt) % 16) * 256);
            if (req_cnt < 16) obs_idx[req_cnt] = int'(o_coef_index);
            req_cnt++;
         end
         if (o_x_ready && i_x_valid) xcnt++;
         if (o_valid) begin
            vcnt++;
            chk("valid_once", vcnt, 1);
            chk("req_count", req_cnt, 16);
            chk("x_count", xcnt, 16);
            chk("re", o_re, exp_re);
            chk("im", o_im, exp_im);
            hold_re = exp_re;
            hold_im = exp_im;
         end else begin
            chk("hold_re", o_re, hold_re);
            chk("hold_im", o_im, hold_im);
         end
      end
   end
   task automatic run(int k, bit g, bit gl, bit stray, output int lat);
      @(negedge clk);
      gaps = g;
      glitch = gl;
      mdl_k = k;
      model(k);
      chk("idle_busy", o_busy, 0);
      i_start = 1;
      i_k = 4'(k);
      @(negedge clk);
      i_start = 0;
      lat = 1;
      chk("busy_rise", o_busy, 1);
      while (!o_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
         if (stray) begin
            i_start = (lat == 20);
            i_k = 4'(k ^ 5);
         end
      end
      i_start = 0;
      if (!o_valid) chk("valid_timeout", 0, 1);
   endtask
   initial begin
      int lat, r0, cyc;
      longint d;
      for (int i = 0; i < 4096; i++) begin
         cos_tab[i] = int'(2047.0 * $cos(2.0 * 3.141592653589793 * i / 4096.0));
         sin_tab[i] = int'(2047.0 * $sin(2.0 * 3.141592653589793 * i / 4096.0));
      end
      foreach (xs[i]) xs[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_im", o_im, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_req", o_coef_req, 0);
      chk("rst_ready", o_x_ready, 0);
      chk("rst_index", o_coef_index, 0);
      @(posedge clk) #3 rst_n = 1;
      foreach (xs[i]) xs[i] = 100;
      run(0, 0, 0, 0, lat);
      chk("dc_latency", lat, 97);
      chk("dc_model", exp_re, 3275200);
      chk("dc_re", o_re, 3275200);
      chk("dc_im", o_im, 0);
      foreach (xs[i]) xs[i] = $urandom_range(0, 4095) - 2048;
      run(3, 0, 0, 0, lat);
      chk("k3_idx1", obs_idx[1], 768);
      chk("k3_idx6_wrap", obs_idx[6], 512);
      chk("k3_idx15", obs_idx[15], 3328);
      foreach (xs[i]) xs[i] = (i == 0) ? 500 : 0;
      for (int k = 0; k < 16; k++) begin
         run(k, k[0], 0, 0, lat);
         chk("impulse_re", o_re, 1023500);
         chk("impulse_im", o_im, 0);
      end
      foreach (xs[i]) xs[i] = int'(1000.0 * cos_tab[(1024 * i) % 4096] / 2047.0);
      run(4, 0, 0, 0, lat);
      r0 = int'(o_re);
      d = longint'(o_re) - 16376000;
      chk("tone_near", (d <= 16000 && d >= -16000) ? 1 : 0, 1);
      run(4, 1, 0, 0, lat);
      chk("tone_gaps_same", o_re, r0);
      foreach (xs[i]) xs[i] = $urandom_range(0, 4095) - 2048;
      run($urandom_range(0, 15), 0, 1, 1, lat);
      chk("glitch_latency", lat, 97);
      foreach (xs[i]) xs[i] = $urandom_range(0, 4095) - 2048;
      @(negedge clk);
      gaps = 0;
      glitch = 0;
      mdl_k = 7;
      model(7);
      i_start = 1;
      i_k = 4'd7;
      @(negedge clk);
      i_start = 0;
      cyc = 0;
      while (xcnt < 7 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_step7", xcnt >= 7 ? 1 : 0, 1);
      @(posedge clk) #3 rst_n = 0;
      #1;
      chk("abort_re", o_re, 0);
      chk("abort_im", o_im, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_req", o_coef_req, 0);
      chk("abort_ready", o_x_ready, 0);
      chk("abort_index", o_coef_index, 0);
      repeat (2) @(negedge clk);
      @(posedge clk) #3 rst_n = 1;
      for (int t = 0; t < 4; t++) begin
         foreach (xs[i]) xs[i] = $urandom_range(0, 4095) - 2048;
         run($urandom_range(0, 15), t[0], t[1], 0, lat);
      end
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dft_bin_acc.md
# dft_bin_acc

Single-bin DFT accumulator that drives the twiddle coefficient table (`coefTabl`) and consumes its output. For a requested bin `k` it steps `n = 0..N-1` and forms the phase index `(k·n mod N)` scaled to the table's WIDTH-bit index space. It requests the cos/sin pair from the table and accepts one input sample per step. It accumulates `X[k] = Σ x[n]·(cos − j·sin)` and presents the complex result with a one-cycle valid pulse.

## Interface
- `WIDTH`, 12: sample, coefficient and table index width.
- `LOG2N`, 4: log2 of transform length N (N=16); LOG2N ≤ WIDTH.
- `ACC_W`, 2·WIDTH+LOG2N: accumulator/result width.

- `i_sys_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous reset, active-low.
- `i_start`  in  1  start pulse, sampled in IDLE only.
- `i_k`  in  LOG2N  bin number, captured on accepted start.
- `i_x`  in  WIDTH signed  input sample x[n].
- `i_x_valid`  in  1  sample valid.
- `o_x_ready`  out  1  block ready for sample.
- `o_coef_index`  out  WIDTH  table index = phase << (WIDTH−LOG2N).
- `o_coef_req`  out  1  one-cycle request pulse to table (drives table start).
- `i_coef_done`  in  1  table output valid.
- `i_c`  in  2×WIDTH signed  [0]=cos, [1]=sin, Q1.(WIDTH−1).
- `o_re`, `o_im`  out  ACC_W signed  result.
- `o_valid`  out  1  one-cycle result pulse.
- `o_busy`  out  1  high outside IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT_COEF, WAIT_X, MAC, DONE.
- IDLE: when `i_start`=1, capture `i_k`, clear n, phase and both accumulators, then go to REQ. `i_start` outside IDLE is ignored.
- REQ: `o_coef_req`=1 for exactly one cycle with `o_coef_index` stable, then go to WAIT_COEF.
  - `o_coef_index` holds from REQ through MAC.
- WAIT_COEF: `i_coef_done` in the REQ cycle is ignored. On the first cycle with `i_coef_done`=1, latch `i_c[0]` and `i_c[1]`, then go to WAIT_X.
- WAIT_X: `o_x_ready`=1. On `i_x_valid`&&`o_x_ready`, latch `i_x`, then go to MAC. Samples offered in other states are not accepted.
- MAC: `re += x·c0`; `im −= x·c1`.
  - Products are full 2·WIDTH signed, sign-extended to ACC_W; no saturation, wrap is impossible by sizing.
  - If n==N−1, go to DONE. Otherwise n+=1, phase=(phase+k) mod 2^LOG2N (natural wrap), go to REQ.
- DONE: `o_valid`=1 for one cycle, then go to IDLE. `o_re`/`o_im` update in DONE and hold until the next DONE or reset.
- Reset values (async, `i_reset`=0): state IDLE, all outputs 0, accumulators, n, phase and latches 0. Reset mid-transform aborts it with no `o_valid`.

## Timing
- Per step: 1 (REQ) + L_coef (cycles until `i_coef_done`, ≥1) + W_x (≥1) + 1 (MAC).
- Start-to-valid: 1 + N·(L_coef+W_x+2) cycles, with the valid pulse in the cycle after the last MAC.
- `o_busy` rises the cycle after the accepted start and falls on the cycle leaving DONE.
- Back-to-back: a start in the cycle after `o_valid` is accepted.

## Structure
- Package `dft_pkg`: WIDTH, LOG2N, ACC_W defaults; state enum type; coefficient pair typedef (2×signed WIDTH).
- Sub-module `dft_cmac`: registered signed complex multiply-accumulate with clear/enable; everything else inline in `dft_bin_acc`.

## Test plan
All scenarios use WIDTH=12, LOG2N=4, and a table model with L_coef=3.
- k=0, x[n]=100 for all n; cos=2047, sin=0 at index 0 → `o_re`=3 275 200, `o_im`=0, single `o_valid`.
- k=3 → `o_coef_index` sequence 0,768,1536,2304,3072,3840,512,1280,… (n=6 gives 512, wrap verified), with exactly 16 `o_coef_req` pulses.
- Impulse x[0]=500, others 0, for k=0..15 → `o_re`=1 023 500, `o_im`=0 for every k.
- k=4, x[n]=1000·cos-table sample at index 1024·n → `o_re`≈16·1000·2047/2 within table rounding; random `i_x_valid` gaps → identical result, no sample lost or duplicated.
- `i_start` pulsed while busy → ignored, result unchanged; `i_coef_done` held high into REQ → not taken as completion.
- `i_reset` low at step 7 → all outputs 0 immediately, no `o_valid`; a new start completes correctly.
